// File: rtl/fht_io_sequencer.sv
// rtl/fht_io_sequencer.sv - frame sequencer for the 4-bank FHT core: ADC load, core start/wait, result unload
// Optional core-wait watchdog is built when FHT_SEQ_TIMEOUT_EN is defined.
module fht_io_sequencer #(
  parameter int D_BIT   = 16,
  parameter int A_BIT   = 8,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 65535
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iEN,
  input  logic [D_BIT-2:0] iADC_DATA,
  input  logic             iADC_VALID,
  output logic [D_BIT-2:0] oDATA,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [3:0]       oWE,
  output logic             oSTART,
  input  logic             iCORE_RDY,
  output logic [A_BIT-1:0] oADDR_RD,
  input  logic [D_BIT-1:0] iBANK_0,
  input  logic [D_BIT-1:0] iBANK_1,
  input  logic [D_BIT-1:0] iBANK_2,
  input  logic [D_BIT-1:0] iBANK_3,
  output logic [D_BIT-1:0] oOUT_DATA,
  output logic             oOUT_VALID,
  input  logic             iOUT_READY,
  output logic             oOUT_LAST,
  output logic             oBUSY,
  output logic             oOVF,
  output logic             oERR
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_FALL, WAIT_RISE, RD_ISSUE, RD_WAIT, EMIT
  } state_t;

  localparam logic [A_BIT+1:0] K_LAST  = '1;
  localparam logic [A_BIT-1:0] A_LAST  = '1;
  localparam logic [1:0]       RD_LAST = 2'(RD_LAT - 1);

  state_t           state, state_nxt;
  logic [A_BIT+1:0] k;
  logic [A_BIT-1:0] a;
  logic [1:0]       b;
  logic [1:0]       rcnt;
  logic [D_BIT-1:0] word_q [4];
  logic             ovf_q;
  logic             err_q;
  logic             we;
  logic             accept;
  logic             timeout_hit;

  assign accept = oOUT_VALID && iOUT_READY;

`ifdef FHT_SEQ_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
  logic          in_wait;

  assign in_wait     = (state == WAIT_FALL) || (state == WAIT_RISE);
  assign timeout_hit = in_wait && (tcnt >= T_LAST);

  // The START cycle counts as the first elapsed cycle, so oERR shows TIMEOUT cycles after START.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == START)
        tcnt <= TW'(1);
      else if (in_wait)
        tcnt <= tcnt + TW'(1);
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (iEN && iADC_VALID) state_nxt = LOAD;
      LOAD:      if (iADC_VALID && (k == K_LAST)) state_nxt = START;
      START:     state_nxt = WAIT_FALL;
      WAIT_FALL: begin
        if (timeout_hit)     state_nxt = IDLE;
        else if (!iCORE_RDY) state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (timeout_hit)    state_nxt = IDLE;
        else if (iCORE_RDY) state_nxt = RD_ISSUE;
      end
      RD_ISSUE:  state_nxt = RD_WAIT;
      RD_WAIT:   if (rcnt == RD_LAST) state_nxt = EMIT;
      EMIT:      if (accept && (b == 2'd3)) state_nxt = (a == A_LAST) ? IDLE : RD_ISSUE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Strobes are gated by iRESET so they drop while reset is held, not one edge later.
  always_comb begin
    we       = !iRESET && iADC_VALID && (((state == IDLE) && iEN) || (state == LOAD));
    oWE      = '0;
    oADDR_WR = '0;
    oDATA    = '0;
    if (we) begin
      oWE      = 4'b0001 << k[1:0];
      oADDR_WR = k[A_BIT+1:2];
      oDATA    = iADC_DATA;
    end
    oSTART     = !iRESET && (state == START);
    oADDR_RD   = (state == RD_ISSUE) ? a : '0;
    oOUT_VALID = !iRESET && (state == EMIT);
    oOUT_DATA  = oOUT_VALID ? word_q[b] : '0;
    oOUT_LAST  = oOUT_VALID && (b == 2'd3) && (a == A_LAST);
    oBUSY      = (state != IDLE);
    oOVF       = ovf_q;
    oERR       = err_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      k      <= '0;
      a      <= '0;
      b      <= '0;
      rcnt   <= '0;
      ovf_q  <= 1'b0;
      word_q <= '{default: '0};
    end else begin
      if (we)
        k <= k + (A_BIT+2)'(1);
      if (iEN && iADC_VALID && (state != IDLE) && (state != LOAD))
        ovf_q <= 1'b1;
      case (state)
        RD_ISSUE: rcnt <= '0;
        RD_WAIT: begin
          rcnt <= rcnt + 2'd1;
          if (rcnt == RD_LAST) begin
            word_q[0] <= iBANK_0;
            word_q[1] <= iBANK_1;
            word_q[2] <= iBANK_2;
            word_q[3] <= iBANK_3;
            b         <= '0;
          end
        end
        EMIT: begin
          if (accept) begin
            b <= b + 2'd1;
            if (b == 2'd3)
              a <= a + A_BIT'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_io_sequencer.sv
// tb/tb_fht_io_sequencer.sv - scoreboard bench for fht_io_sequencer with bank RAM and core ready model
module tb_fht_io_sequencer;
  localparam int D_BIT   = 16;
  localparam int A_BIT   = 2;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 50;
  localparam int N       = 4 << A_BIT;

  logic             iCLK = 1'b0;
  logic             iRESET = 1'b1;
  logic             iEN = 1'b0;
  logic [D_BIT-2:0] iADC_DATA = '0;
  logic             iADC_VALID = 1'b0;
  logic [D_BIT-2:0] oDATA;
  logic [A_BIT-1:0] oADDR_WR;
  logic [3:0]       oWE;
  logic             oSTART;
  logic             iCORE_RDY = 1'b1;
  logic [A_BIT-1:0] oADDR_RD;
  logic [D_BIT-1:0] iBANK_0, iBANK_1, iBANK_2, iBANK_3;
  logic [D_BIT-1:0] oOUT_DATA;
  logic             oOUT_VALID;
  logic             iOUT_READY = 1'b1;
  logic             oOUT_LAST;
  logic             oBUSY;
  logic             oOVF;
  logic             oERR;

  fht_io_sequencer #(.D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN), .iADC_DATA(iADC_DATA), .iADC_VALID(iADC_VALID),
    .oDATA(oDATA), .oADDR_WR(oADDR_WR), .oWE(oWE), .oSTART(oSTART), .iCORE_RDY(iCORE_RDY),
    .oADDR_RD(oADDR_RD), .iBANK_0(iBANK_0), .iBANK_1(iBANK_1), .iBANK_2(iBANK_2), .iBANK_3(iBANK_3),
    .oOUT_DATA(oOUT_DATA), .oOUT_VALID(oOUT_VALID), .iOUT_READY(iOUT_READY), .oOUT_LAST(oOUT_LAST),
    .oBUSY(oBUSY), .oOVF(oOVF), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int             tests = 0;
  int             fails = 0;
  logic [D_BIT:0] exp_q [$];
  logic [D_BIT-1:0] ram  [4][1 << A_BIT];
  logic [D_BIT-1:0] rd_q [4];
  bit             bp = 1'b0;
  bit             stuck = 1'b0;
  bit             core_phase = 1'b0;
  int             start_cnt = 0;
  int             early_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bank RAM: one-cycle registered read, written from the DUT's scatter port.
  always @(posedge iCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (oWE[i]) ram[i][oADDR_WR] <= {1'b0, oDATA};
      rd_q[i] <= ram[i][oADDR_RD];
    end
  end
  assign iBANK_0 = rd_q[0];
  assign iBANK_1 = rd_q[1];
  assign iBANK_2 = rd_q[2];
  assign iBANK_3 = rd_q[3];

  // Core ready: falls 5 cycles after START, rises 200 cycles later.
  initial begin
    forever begin
      @(negedge iCLK);
      if (oSTART && !stuck) begin
        core_phase = 1'b1;
        repeat (5) @(posedge iCLK);
        #1 iCORE_RDY = 1'b0;
        repeat (200) @(posedge iCLK);
        #1 iCORE_RDY = 1'b1;
        core_phase = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge iCLK);
      #1 iOUT_READY = bp ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  initial begin : monitor
    logic             held;
    logic [D_BIT-1:0] held_data;
    logic [D_BIT:0]   e;
    held = 1'b0;
    held_data = '0;
    forever begin
      @(negedge iCLK);
      if (oSTART) start_cnt++;
      if (held) check("valid_held_while_stalled", 32'(oOUT_VALID), 32'd1);
      if (oOUT_VALID) begin
        if (core_phase) early_cnt++;
        if (held) check("data_stable_while_stalled", 32'(oOUT_DATA), 32'(held_data));
        if (iOUT_READY) begin
          if (exp_q.size() == 0) begin
            check("stream_extra_word", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("stream_data", 32'(oOUT_DATA), 32'(e[D_BIT-1:0]));
            check("stream_last", 32'(oOUT_LAST), 32'(e[D_BIT]));
          end
        end
        held = !iOUT_READY;
        held_data = oOUT_DATA;
      end else begin
        held = 1'b0;
      end
    end
  end

  function automatic logic [D_BIT-2:0] sample(input int pat, input int k);
    case (pat)
      0:       return (D_BIT-1)'(100 * (k % 4) + k / 4);
      1:       return (D_BIT-1)'(32767 - 37 * k);
      default: return (D_BIT-1)'(1000 + k * k);
    endcase
  endfunction

  task automatic load_frame(input int pat, input bit push);
    for (int k = 0; k < N; k++) begin
      if (k == 8) begin
        @(posedge iCLK);
        #1 iADC_VALID = 1'b0;
        @(negedge iCLK);
        check("load_gap_no_we", 32'(oWE), 32'd0);
      end
      @(posedge iCLK);
      #1;
      iEN = 1'b1;
      iADC_VALID = 1'b1;
      iADC_DATA = sample(pat, k);
      @(negedge iCLK);
      check("load_we", 32'(oWE), 32'(1 << (k % 4)));
      check("load_addr", 32'(oADDR_WR), 32'(k / 4));
      check("load_data", 32'(oDATA), 32'(sample(pat, k)));
      if (k == 6) begin
        check("s6_we_bank2", 32'(oWE), 32'h4);
        check("s6_addr1", 32'(oADDR_WR), 32'd1);
      end
      if (k == 15) begin
        check("s15_we_bank3", 32'(oWE), 32'h8);
        check("s15_addr3", 32'(oADDR_WR), 32'd3);
      end
      if (push) exp_q.push_back({(k == N - 1), 1'b0, sample(pat, k)});
    end
    @(posedge iCLK);
    #1;
    iADC_VALID = 1'b0;
    iEN = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge iCLK);
    while (oBUSY && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    check(name, 32'(oBUSY), 32'd0);
  endtask

  task automatic run_frame(input int pat, input bit bpv, input bit inject);
    int s0;
    s0 = start_cnt;
    bp = bpv;
    load_frame(pat, 1'b1);
    if (inject) begin
      for (int i = 0; i < 50 && iCORE_RDY; i++) @(posedge iCLK);
      repeat (10) @(posedge iCLK);
      #1;
      iEN = 1'b1;
      iADC_VALID = 1'b1;
      iADC_DATA = '1;
      @(negedge iCLK);
      check("ovf_no_we", 32'(oWE), 32'd0);
      check("ovf_busy", 32'(oBUSY), 32'd1);
      @(posedge iCLK);
      #1;
      iADC_VALID = 1'b0;
      iEN = 1'b0;
      @(negedge iCLK);
      check("ovf_sticky_set", 32'(oOVF), 32'd1);
    end
    wait_idle("frame_done");
    check("frame_queue_empty", 32'(exp_q.size()), 32'd0);
    check("start_one_pulse", 32'(start_cnt - s0), 32'd1);
    check("no_unload_before_core_done", 32'(early_cnt), 32'd0);
    bp = 1'b0;
  endtask

  initial begin
    int j_hit;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check("reset_strobes", 32'({oWE, oSTART, oOUT_VALID, oOUT_LAST, oBUSY, oOVF, oERR}), 32'd0);
    check("reset_buses", 32'({oDATA, oADDR_WR, oADDR_RD}), 32'd0);
    check("reset_out_data", 32'(oOUT_DATA), 32'd0);
    @(posedge iCLK);
    #1 iRESET = 1'b0;

    // Samples with iEN low are ignored in IDLE.
    iADC_VALID = 1'b1;
    iADC_DATA = 15'd77;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      check("idle_en_low_no_we", 32'(oWE), 32'd0);
    end
    @(posedge iCLK);
    #1 iADC_VALID = 1'b0;
    @(negedge iCLK);
    check("idle_en_low_busy", 32'(oBUSY), 32'd0);
    check("idle_en_low_no_ovf", 32'(oOVF), 32'd0);

    // Reset held 3 cycles in the middle of a load.
    for (int k = 0; k < 5; k++) begin
      @(posedge iCLK);
      #1;
      iEN = 1'b1;
      iADC_VALID = 1'b1;
      iADC_DATA = 15'(500 + k);
    end
    @(negedge iCLK);
    check("midload_busy", 32'(oBUSY), 32'd1);
    @(posedge iCLK);
    #1 iRESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      check("reset_hold_no_we", 32'(oWE), 32'd0);
      if (i > 0) check("reset_hold_idle", 32'(oBUSY), 32'd0);
      @(posedge iCLK);
      #1;
    end
    iRESET = 1'b0;
    iADC_VALID = 1'b0;
    iEN = 1'b0;
    @(negedge iCLK);
    check("after_reset_busy", 32'(oBUSY), 32'd0);
    check("after_reset_strobes", 32'({oWE, oSTART, oOUT_VALID, oOVF, oERR}), 32'd0);

    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b1, 1'b0);
    check("no_ovf_before_inject", 32'(oOVF), 32'd0);
    run_frame(2, 1'b0, 1'b1);

`ifdef FHT_SEQ_TIMEOUT_EN
    stuck = 1'b1;
    load_frame(0, 1'b0);
    @(negedge iCLK);
    check("timeout_start", 32'(oSTART), 32'd1);
    j_hit = -1;
    for (int j = 1; j <= 60; j++) begin
      @(negedge iCLK);
      if (oERR && j_hit < 0) begin
        j_hit = j;
        check("timeout_back_to_idle", 32'(oBUSY), 32'd0);
      end
    end
    check("timeout_err_cycle", 32'(j_hit), 32'd50);
    check("timeout_err_sticky", 32'(oERR), 32'd1);
    stuck = 1'b0;
`else
    j_hit = 0;
    check("err_tied_low", 32'(oERR), 32'(j_hit));
`endif
    check("ovf_still_sticky", 32'(oOVF), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
